reg_file_bypass: RTL and testbench

Parametrised successor to the core's integer register file. It provides two asynchronous read ports and two synchronous write ports, with register 0 hardwired to zero. Same-cycle write-to-read bypass lets the pipeline read a value in the cycle it is written. After reset, a built-in clear sequencer zeroes every register one per cycle. A debug read port lets the testbench or top level observe any register, replacing the fixed a0 tap. It sits between decode (reads) and writeback (writes) in the single-issue/dual-writeback pipeline.

---
 rtl/reg_file_bypass.sv | 133 +++++++++++++
 tb/tb_reg_file_bypass.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/reg_file_bypass.sv
// rtl/reg_file_bypass.sv - dual-read/dual-write register file with write-to-read bypass
// Register 0 reads as zero. A post-reset sequencer zeroes x1..x(DEPTH-1) one per cycle while busy is high.
module reg_file_bypass #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int DBG_DEFAULT = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] A1,
  input  logic [ADDR_WIDTH-1:0] A2,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2,
  input  logic [ADDR_WIDTH-1:0] A3,
  input  logic [DATA_WIDTH-1:0] WD3,
  input  logic                  WE3,
  input  logic [ADDR_WIDTH-1:0] A4,
  input  logic [DATA_WIDTH-1:0] WD4,
  input  logic                  WE4,
  input  logic                  dbg_en,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data,
  output logic                  busy
);

  localparam int                  DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;
  localparam logic [ADDR_WIDTH-1:0] DBG_IDX  = ADDR_WIDTH'(DBG_DEFAULT);

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_idx;
  logic [ADDR_WIDTH-1:0] w_clr_idx_nxt;
  logic                  w_clr_we;
  logic                  w_busy;
  logic [ADDR_WIDTH-1:0] w_dbg_sel;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= CLEAR;
      r_clr_idx <= ADDR_WIDTH'(1);
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    w_clr_we      = 1'b0;
    case (r_state)
      CLEAR: begin
        w_clr_we      = 1'b1;
        w_clr_idx_nxt = r_clr_idx + ADDR_WIDTH'(1);
        if (r_clr_idx == LAST_IDX) begin
          w_state_nxt = IDLE;
        end
      end
      IDLE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = CLEAR;
      end
    endcase
  end

  assign w_busy = rst || (r_state != IDLE);
  assign busy   = w_busy;

  // Port B is written last so it wins when both ports target the same register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_clr_we) begin
        r_mem[r_clr_idx] <= '0;
      end else begin
        if (WE3 && (A3 != '0)) begin
          r_mem[A3] <= WD3;
        end
        if (WE4 && (A4 != '0)) begin
          r_mem[A4] <= WD4;
        end
      end
    end
  end

  function automatic logic [DATA_WIDTH-1:0] f_read(
    input logic                  busy_i,
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0] stored,
    input logic                  we3_i,
    input logic [ADDR_WIDTH-1:0] a3_i,
    input logic [DATA_WIDTH-1:0] wd3_i,
    input logic                  we4_i,
    input logic [ADDR_WIDTH-1:0] a4_i,
    input logic [DATA_WIDTH-1:0] wd4_i
  );
    logic [DATA_WIDTH-1:0] v;
    v = stored;
    if (busy_i || (addr == '0)) begin
      v = '0;
    end else if (we4_i && (a4_i == addr)) begin
      v = wd4_i;
    end else if (we3_i && (a3_i == addr)) begin
      v = wd3_i;
    end
    return v;
  endfunction

  always_comb begin
    RD1 = f_read(w_busy, A1, r_mem[A1], WE3, A3, WD3, WE4, A4, WD4);
    RD2 = f_read(w_busy, A2, r_mem[A2], WE3, A3, WD3, WE4, A4, WD4);
  end

  // Debug tap shows committed storage only; in-flight writes are not bypassed.
  assign w_dbg_sel = dbg_en ? dbg_addr : DBG_IDX;

  always_comb begin
    dbg_data = r_mem[w_dbg_sel];
    if (w_busy || (w_dbg_sel == '0)) begin
      dbg_data = '0;
    end
  end

endmodule

// File: tb/tb_reg_file_bypass.sv
// tb/tb_reg_file_bypass.sv - scoreboard bench for reg_file_bypass
// Expected read values come from a reference model of storage, pushed when stimulus is applied.
module tb_reg_file_bypass;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  A1, A2, A3, A4, dbg_addr;
  logic [31:0] RD1, RD2, WD3, WD4, dbg_data;
  logic        WE3, WE4, dbg_en, busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] dbg;
    logic        busy;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_mem [32];
  logic        m_busy;

  reg_file_bypass dut (
    .clk(clk), .rst(rst),
    .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
    .A3(A3), .WD3(WD3), .WE3(WE3),
    .A4(A4), .WD4(WD4), .WE4(WE4),
    .dbg_en(dbg_en), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (m_busy || a == 5'd0) return 32'd0;
    if (WE4 && A4 == a) return WD4;
    if (WE3 && A3 == a) return WD3;
    return m_mem[a];
  endfunction

  function automatic logic [31:0] m_dbg();
    logic [4:0] s;
    s = dbg_en ? dbg_addr : 5'd10;
    if (m_busy || s == 5'd0) return 32'd0;
    return m_mem[s];
  endfunction

  // Called #1 after a rising edge: apply inputs, predict, sample at negedge, advance one edge.
  task automatic step(input logic [4:0] a1, input logic [4:0] a2,
                      input logic we3, input logic [4:0] a3, input logic [31:0] wd3,
                      input logic we4, input logic [4:0] a4, input logic [31:0] wd4,
                      input logic den, input logic [4:0] dadr);
    exp_t e;
    A1 = a1; A2 = a2; WE3 = we3; A3 = a3; WD3 = wd3;
    WE4 = we4; A4 = a4; WD4 = wd4; dbg_en = den; dbg_addr = dadr;
    e.rd1 = m_read(a1);
    e.rd2 = m_read(a2);
    e.dbg = m_dbg();
    e.busy = m_busy;
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    chk("rd1", RD1, e.rd1);
    chk("rd2", RD2, e.rd2);
    chk("dbg", dbg_data, e.dbg);
    chk("busy", {31'd0, busy}, {31'd0, e.busy});
    @(posedge clk);
    if (!m_busy) begin
      if (we3 && a3 != 5'd0) m_mem[a3] = wd3;
      if (we4 && a4 != 5'd0) m_mem[a4] = wd4;
    end
    #1;
  endtask

  task automatic idle_step(input logic [4:0] a1);
    step(a1, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    m_busy = 1'b1;
    for (int i = 0; i < cycles; i++) idle_step(5'd9);
    rst = 1'b0;
  endtask

  // Counts negedges with busy high from now on; bounded so a stuck sequencer still ends the run.
  task automatic wait_clear(input string tag, input int exp_cycles);
    int cnt = 0;
    WE3 = 1'b0; WE4 = 1'b0;
    @(negedge clk);
    while (busy && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    chk(tag, cnt, exp_cycles);
    @(posedge clk); #1;
    for (int i = 1; i < 32; i++) m_mem[i] = 32'd0;
    m_busy = 1'b0;
  endtask

  initial begin
    rst = 1'b1; m_busy = 1'b1;
    A1 = '0; A2 = '0; A3 = '0; A4 = '0; WD3 = '0; WD4 = '0;
    WE3 = 1'b0; WE4 = 1'b0; dbg_en = 1'b0; dbg_addr = '0;
    for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
    @(posedge clk); #1;

    // reset and clear length, outputs forced to zero while busy
    step(5'd5, 5'd6, 1'b1, 5'd5, 32'hAAAA, 1'b1, 5'd6, 32'hBBBB, 1'b0, 5'd0);
    do_reset(1);
    wait_clear("clear_len", 31);
    for (int i = 1; i < 32; i++)
      step(5'(i), 5'(32 - i), 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(i));

    // bypass on port A then readback from storage
    step(5'd5, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    idle_step(5'd5);

    // both ports same address: port B wins for read and storage
    step(5'd0, 5'd7, 1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 1'b0, 5'd0);
    step(5'd7, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);

    // distinct addresses on both ports, cross-read
    step(5'd12, 5'd13, 1'b1, 5'd13, 32'hCAFE0013, 1'b1, 5'd12, 32'hBEEF0012, 1'b0, 5'd0);
    step(5'd12, 5'd13, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd13);

    // register 0 ignores writes and never bypasses
    step(5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0);
    step(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);

    // debug port: default tap x10 (no bypass on write cycle), then selected x3
    step(5'd10, 5'd0, 1'b1, 5'd10, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    step(5'd0, 5'd3, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'hABCD, 1'b0, 5'd0);
    step(5'd3, 5'd10, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
    idle_step(5'd31);

    // reset from IDLE clears storage; write during CLEAR is dropped
    step(5'd9, 5'd0, 1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    do_reset(1);
    idle_step(5'd4);
    idle_step(5'd4);
    step(5'd4, 5'd4, 1'b1, 5'd4, 32'h77, 1'b1, 5'd4, 32'h88, 1'b1, 5'd4);
    wait_clear("clear_rem", 28);
    step(5'd9, 5'd4, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);

    // reset mid-CLEAR restarts the full count
    do_reset(2);
    for (int i = 0; i < 10; i++) idle_step(5'd1);
    do_reset(1);
    wait_clear("clear_restart", 31);
    idle_step(5'd7);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1);
  end

endmodule
